sel_scan_arbiter: RTL and testbench
===================================

# sel_scan_arbiter

Round-robin select generator that sits directly upstream of the 4:1 vector mux. It watches four channel request lines, grants one channel at a time, and drives the mux select `s[1:0]` for a programmable dwell period. It also emits a one-hot grant and status strobes, so downstream logic knows which source is routed to `y` and when the route changes.

## Interface
Parameters:
- `DWELL`, 4, cycles each grant is held; legal 1..255.
- `CW`, 8, dwell counter width; must satisfy DWELL ≤ 2^CW−1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  per-channel request; bit k asks for mux input `i[k]`.
- `s`  out  2  mux select, registered; binary index of the granted channel.
- `grant`  out  4  one-hot grant, registered; all zeros when idle.
- `busy`  out  1  high while in HOLD.
- `switch_p`  out  1  one-cycle pulse on every cycle a new grant takes effect.

## Operation
- State machine with two states: IDLE and HOLD. Internal registers: 2-bit `last` (last granted index) and a CW-bit dwell counter `cnt`.
- Round-robin search: candidates are scanned in the order `last+1, last+2, last+3, last`, modulo 4. The first asserted `req` bit wins. The index wraps from 3 to 0.
- IDLE → HOLD: any `req` bit is high. The winner is loaded into `s`, `grant` and `last`; `cnt` is set to DWELL−1; `switch_p` = 1.
- HOLD, `cnt` > 0 and `req[s]` high: `cnt` decrements; outputs are held.
- HOLD end condition: `cnt` == 0, or `req[s]` has dropped (early release). On the end condition:
  - If another search finds a winner, regrant immediately with no idle gap and pulse `switch_p`. The same channel may be re-won only if it is the sole requester, and `switch_p` pulses in that case too.
  - If there is no winner, go to IDLE with `grant` = 0 and `busy` = 0.
- Requests that change mid-dwell do not pre-empt the current grant; only the granted channel's own `req` can shorten it.
- With `DWELL` = 1, every HOLD cycle is an end condition, so arbitration occurs each cycle.
- Reset values: state IDLE; `s` = 2'b00; `grant` = 4'b0000; `busy` = 0; `switch_p` = 0; `last` = 2'b11, so the first search starts at channel 0; `cnt` = 0.
- Reset has priority over every transition. Asserting it mid-HOLD returns all outputs to their reset values on the next edge.

## Timing
- Latency: `req` sampled at edge N gives a grant that is visible after edge N, i.e. valid during cycle N+1.
- A full dwell spans exactly DWELL cycles of `busy` = 1 per grant, unless early release occurs.
- Early release: `req[s]` low at edge M means the new grant, or IDLE, is visible after edge M.
- Back-to-back grants: `busy` stays high continuously, and `switch_p` is high for one cycle at each handover.
- `s` changes only on the edges where `switch_p` is asserted. In IDLE, `s` follows the Configuration rule.

## Configuration
- Macro `SEL_SCAN_PARK_EN`.
  - Defined: in IDLE, `s` parks on `last`. The mux keeps routing the most recently granted input, so there are no select glitches toward channel 0.
  - Undefined: on entering IDLE, `s` returns to 2'b00 and holds there until the next grant.
- `grant`, `busy` and `switch_p` behave identically with or without the macro.

## Structure
- Shared package `sel_scan_pkg`:
  - state enum (IDLE, HOLD);
  - `NCH` = 4;
  - `SEL_W` = 2;
  - function `rr_pick(req, last)` returning a found bit and an index.
- One sub-module is natural: `rr_pick4`, a purely combinational rotate/priority-encode that returns the winner index and a valid flag. The FSM, counter and output registers stay in the top-level module.

## Test plan
- Reset → hold `rst` for 2 cycles with `req` = 4'b1111 → after release, first grant is `s` = 0, `grant` = 4'b0001, `switch_p` pulses once.
- Full rotation → `DWELL` = 4, `req` = 4'b1111 constant → `s` sequence 0,1,2,3,0, each held exactly 4 cycles, `busy` never drops, 5 `switch_p` pulses over 20 cycles.
- Early release → `req` = 4'b0100 with channel 2 granted, drop `req[2]` after 1 cycle → IDLE next edge, `grant` = 0; `s` = 2 with `SEL_SCAN_PARK_EN` defined, `s` = 0 without.
- Skip and wrap → `last` = 3, `req` = 4'b1010 → grant channel 1, then channel 3, then channel 1 again.
- Sole requester → `req` = 4'b1000 held, `DWELL` = 2 → `s` = 3 throughout, `switch_p` every 2 cycles, `busy` constant 1.
- Reset mid-HOLD → assert `rst` at dwell count 2 → next edge `s` = 0, `grant` = 0, `busy` = 0; after release, search restarts at channel 0.

Source files
------------

// File: rtl/sel_scan_pkg.sv
// sel_scan_pkg: shared definitions for the round-robin mux-select arbiter.
//   NCH     - number of request channels (4)
//   SEL_W   - width of the mux select / channel index (2)
//   state_e - arbiter FSM states (IDLE, HOLD)
//   pick_t  - result of a round-robin search (found flag + winning index)
//   rr_pick - round-robin search starting one past the last granted channel
package sel_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan last+1, last+2, last+3, last (mod 4); the first asserted request wins.
    // The previous owner is checked last, so it only wins again when it is the
    // sole requester.
    function automatic pick_t rr_pick(input logic [NCH-1:0] req,
                                      input logic [SEL_W-1:0] last);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = 2'b00;
        for (int k = 1; k <= NCH; k++) begin
            cand = last + SEL_W'(k);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end else begin
                res.found = res.found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_scan_arbiter_rr_pick4.sv
// rr_pick4: purely combinational rotate/priority-encode for the arbiter.
// Ports:
//   req   in  4  channel requests
//   last  in  2  most recently granted channel (search starts at last+1)
//   found out 1  at least one request asserted
//   idx   out 2  winning channel index (2'b00 when nothing found)
module rr_pick4
    import sel_scan_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    pick_t pick_s;

    // Evaluate the round-robin search for the current request vector.
    always_comb begin
        pick_s = rr_pick(req, last);
    end

    assign found = pick_s.found;
    assign idx   = pick_s.idx;

endmodule

// File: rtl/sel_scan_arbiter.sv
// sel_scan_arbiter: round-robin select generator for a 4:1 vector mux.
// Grants one requesting channel at a time, holding it for DWELL cycles unless
// the owner drops its request early, and drives the mux select.
// Parameters:
//   DWELL  cycles each grant is held (1..255)
//   CW     dwell counter width (DWELL <= 2^CW-1)
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  synchronous active-high reset
//   req       in  4  per-channel request
//   s         out 2  registered mux select (index of granted channel)
//   grant     out 4  registered one-hot grant, zero when idle
//   busy      out 1  high while a grant is held
//   switch_p  out 1  one-cycle pulse on each cycle a new grant takes effect
// Configuration macro:
//   SEL_SCAN_PARK_EN  when defined, s stays on the last granted channel in
//                     IDLE; otherwise s returns to 2'b00 on entering IDLE.
module sel_scan_arbiter
    import sel_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    output logic [SEL_W-1:0] s,
    output logic [NCH-1:0]   grant,
    output logic             busy,
    output logic             switch_p
);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);

    state_e           state_r;
    logic [SEL_W-1:0] last_r;
    logic [CW-1:0]    cnt_r;
    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             hold_end_s;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // A held grant ends when its dwell expires or its owner releases early.
    always_comb begin
        hold_end_s = (cnt_r == {CW{1'b0}}) || !req[s];
    end

    // Arbiter FSM, dwell counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            last_r   <= 2'b11;
            cnt_r    <= {CW{1'b0}};
            s        <= 2'b00;
            grant    <= 4'b0000;
            busy     <= 1'b0;
            switch_p <= 1'b0;
        end else begin
            switch_p <= 1'b0;
            case (state_r)
                IDLE, HOLD: begin
                    if (state_r == HOLD && !hold_end_s) begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end else if (pick_found_s) begin
                        // New grant (or re-grant of a sole requester).
                        state_r  <= HOLD;
                        last_r   <= pick_idx_s;
                        cnt_r    <= DWELL_LOAD;
                        s        <= pick_idx_s;
                        grant    <= 4'b0001 << pick_idx_s;
                        busy     <= 1'b1;
                        switch_p <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                        grant   <= 4'b0000;
                        busy    <= 1'b0;
`ifdef SEL_SCAN_PARK_EN
                        // s already equals last_r after any grant; keep routing it.
                        s       <= s;
`else
                        s       <= 2'b00;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CW{1'b0}};
                    s       <= 2'b00;
                    grant   <= 4'b0000;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_scan_arbiter.sv
// Bench for sel_scan_arbiter: two instances (DWELL=4 and DWELL=2) share the
// same stimulus; each is compared every cycle against a channel-ownership
// model derived from the arbitration rules.
module tb_sel_scan_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] s_o     [2];
    logic [3:0] grant_o [2];
    logic       busy_o  [2];
    logic       sw_o    [2];

    int vectors;
    int miscompares;

    // Reference model: owner = granted channel (-1 when idle), rem = cycles
    // of dwell still to run including the current one.
    int dw     [2];
    int owner  [2];
    int last_m [2];
    int rem    [2];
    int s_m    [2];
    bit sw_m   [2];
    logic [3:0] prev_req;

    sel_scan_arbiter #(.DWELL(4), .CW(8)) u_dut4 (
        .clk(clk), .rst(rst), .req(req),
        .s(s_o[0]), .grant(grant_o[0]), .busy(busy_o[0]), .switch_p(sw_o[0])
    );

    sel_scan_arbiter #(.DWELL(2), .CW(8)) u_dut2 (
        .clk(clk), .rst(rst), .req(req),
        .s(s_o[1]), .grant(grant_o[1]), .busy(busy_o[1]), .switch_p(sw_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update(input int j, input logic [3:0] r, input logic rs);
        bit do_search;
        int win;
        if (rs) begin
            owner[j] = -1; last_m[j] = 3; rem[j] = 0; s_m[j] = 0; sw_m[j] = 1'b0;
        end else begin
            do_search = (owner[j] < 0) || (rem[j] == 1) || !r[owner[j]];
            if (!do_search) begin
                rem[j]  = rem[j] - 1;
                sw_m[j] = 1'b0;
            end else begin
                win = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (win < 0 && r[(last_m[j] + k) % 4]) win = (last_m[j] + k) % 4;
                end
                if (win >= 0) begin
                    owner[j] = win; last_m[j] = win; rem[j] = dw[j];
                    s_m[j] = win; sw_m[j] = 1'b1;
                end else begin
`ifndef SEL_SCAN_PARK_EN
                    if (owner[j] >= 0) s_m[j] = 0;
`endif
                    owner[j] = -1; rem[j] = 0; sw_m[j] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rs);
        logic [3:0] g_exp;
        req = r;
        rst = rs;
        @(posedge clk);
        #1;
        vectors++;
        for (int j = 0; j < 2; j++) begin
            model_update(j, r, rs);
            g_exp = (owner[j] < 0) ? 4'b0000 : (4'b0001 << owner[j]);
            assert (s_o[j] === 2'(s_m[j])) else begin
                miscompares++;
                $error("FAIL s[%0d] vec %0d: got %0d want %0d", j, vectors, s_o[j], s_m[j]);
            end
            assert (grant_o[j] === g_exp) else begin
                miscompares++;
                $error("FAIL grant[%0d] vec %0d: got %b want %b", j, vectors, grant_o[j], g_exp);
            end
            assert (busy_o[j] === (owner[j] >= 0)) else begin
                miscompares++;
                $error("FAIL busy[%0d] vec %0d: got %b want %b", j, vectors, busy_o[j], owner[j] >= 0);
            end
            assert (sw_o[j] === sw_m[j]) else begin
                miscompares++;
                $error("FAIL switch_p[%0d] vec %0d: got %b want %b", j, vectors, sw_o[j], sw_m[j]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dw[0] = 4;
        dw[1] = 2;
        req = 4'b0000;
        rst = 1'b1;

        // Reset held two cycles with all channels requesting.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        // Full rotation: 0,1,2,3,0 then continue.
        for (int i = 0; i < 20; i++) step(4'b1111, 1'b0);
        // Go idle, then grant channel 2 and release it early.
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        // Skip and wrap from last = 3 after reset.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b1010, 1'b0);
        // Sole requester re-wins channel 3 with a pulse every dwell.
        for (int i = 0; i < 8; i++) step(4'b1000, 1'b0);
        // Reset in the middle of a hold, then restart at channel 0.
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b0);
        // DWELL-independent single-cycle requests.
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);

        // Randomised traffic with sticky requests and rare resets.
        prev_req = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) prev_req = 4'($urandom);
            step(prev_req, ($urandom_range(0, 60) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
